// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: ALU op codes, RISC-V opcodes and FSM state encoding.
// The ALU_SEQ_SHIFT_EN build option, which enables SLL/SRL decode, is used by alu_seq_decoder.
package alu_seq_pkg;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_OR    = 4'd2;
   localparam logic [3:0] ALU_AND   = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_LUI   = 4'd5;
   localparam logic [3:0] ALU_SLL   = 4'd6;
   localparam logic [3:0] ALU_SRL   = 4'd7;
   localparam logic [3:0] ALU_BEQ   = 4'd8;
   localparam logic [3:0] ALU_BNE   = 4'd9;
   localparam logic [3:0] ALU_AUIPC = 4'd15;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic        illegal;
      logic        is_branch;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } dec_t;

endpackage

// File: rtl/alu_seq_decoder.sv
// Combinational instruction decoder: instruction fields to ALU op, operands and illegal flag.
// Define ALU_SEQ_SHIFT_EN to decode SLL/SRL; otherwise funct3 001/101 on R/I opcodes is illegal.
module alu_seq_decoder
   import alu_seq_pkg::*;
(
   input  logic [6:0]  i_opcode,
   input  logic [2:0]  i_funct3,
   input  logic        i_funct7b5,
   input  logic [31:0] i_rs1,
   input  logic [31:0] i_rs2,
   input  logic [31:0] i_imm,
   input  logic [31:0] i_pc,
   output dec_t        o_dec
);

   logic       w_is_r;
   logic       w_f7_set_r;
   logic [3:0] w_arith_op;
   logic       w_arith_ok;

   assign w_is_r     = (i_opcode == OPC_R);
   assign w_f7_set_r = w_is_r & i_funct7b5;

   // funct3 table shared by R and I forms; funct7b5 only selects SUB on R-type
   always_comb begin
      w_arith_op = ALU_ADD;
      w_arith_ok = 1'b0;
      case (i_funct3)
         3'b000: begin
            w_arith_op = w_f7_set_r ? ALU_SUB : ALU_ADD;
            w_arith_ok = 1'b1;
         end
         3'b110: begin
            w_arith_op = ALU_OR;
            w_arith_ok = !w_f7_set_r;
         end
         3'b111: begin
            w_arith_op = ALU_AND;
            w_arith_ok = !w_f7_set_r;
         end
         3'b100: begin
            w_arith_op = ALU_XOR;
            w_arith_ok = !w_f7_set_r;
         end
`ifdef ALU_SEQ_SHIFT_EN
         3'b001: begin
            w_arith_op = ALU_SLL;
            w_arith_ok = !w_f7_set_r;
         end
         3'b101: begin
            w_arith_op = ALU_SRL;
            w_arith_ok = !i_funct7b5;
         end
`else
         3'b001:  w_arith_ok = 1'b0;
         3'b101:  w_arith_ok = 1'b0;
`endif
         default: w_arith_ok = 1'b0;
      endcase
   end

   always_comb begin
      o_dec         = '0;
      o_dec.illegal = 1'b1;
      case (i_opcode)
         OPC_R, OPC_I: begin
            o_dec.illegal = !w_arith_ok;
            o_dec.op      = w_arith_op;
            o_dec.a       = i_rs1;
            o_dec.b       = w_is_r ? i_rs2 : i_imm;
         end
         OPC_LUI: begin
            o_dec.illegal = 1'b0;
            o_dec.op      = ALU_LUI;
            o_dec.b       = i_imm;
         end
         OPC_AUIPC: begin
            o_dec.illegal = 1'b0;
            o_dec.op      = ALU_AUIPC;
            o_dec.a       = i_pc;
            o_dec.b       = i_imm;
         end
         OPC_BRANCH: begin
            o_dec.illegal   = (i_funct3[2:1] != 2'b00);
            o_dec.is_branch = 1'b1;
            o_dec.op        = i_funct3[0] ? ALU_BNE : ALU_BEQ;
            o_dec.a         = i_rs1;
            o_dec.b         = i_rs2;
         end
         default: o_dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one instruction at a time through an external combinational ALU: IDLE -> EXEC -> RESP.
// Decode lives in alu_seq_decoder; build option ALU_SEQ_SHIFT_EN enables shift decode there.
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        Req_Valid_i,
   output logic        Req_Ready_o,
   input  logic [6:0]  Opcode_i,
   input  logic [2:0]  Funct3_i,
   input  logic [0:0]  Funct7b5_i,
   input  logic [31:0] Rs1_i,
   input  logic [31:0] Rs2_i,
   input  logic [31:0] Imm_i,
   input  logic [31:0] PC_i,
   output logic [3:0]  ALU_Operation_o,
   output logic [31:0] A_o,
   output logic [31:0] B_o,
   input  logic [31:0] ALU_Result_i,
   input  logic        Zero_i,
   output logic        Rsp_Valid_o,
   input  logic        Rsp_Ready_i,
   output logic [31:0] Rsp_Result_o,
   output logic        Rsp_Branch_Taken_o,
   output logic        Rsp_Illegal_o,
   output logic [1:0]  o_dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // the source holds its payload stable while valid is high and ready is low.

   seq_state_t  r_state;
   seq_state_t  w_state_next;
   logic [3:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        r_is_branch;
   logic [31:0] r_rsp_result;
   logic        r_rsp_taken;
   logic        r_rsp_illegal;
   dec_t        w_dec;
   logic        w_accept;

   alu_seq_decoder u_decoder (
      .i_opcode   (Opcode_i),
      .i_funct3   (Funct3_i),
      .i_funct7b5 (Funct7b5_i[0]),
      .i_rs1      (Rs1_i),
      .i_rs2      (Rs2_i),
      .i_imm      (Imm_i),
      .i_pc       (PC_i),
      .o_dec      (w_dec)
   );

   assign w_accept = (r_state == ST_IDLE) & Req_Valid_i;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (Req_Valid_i) w_state_next = w_dec.illegal ? ST_RESP : ST_EXEC;
         ST_EXEC: w_state_next = ST_RESP;
         ST_RESP: if (Rsp_Ready_i) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ALU-side registers change only on a legal accept, so they hold the last issue elsewhere
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op          <= '0;
         r_a           <= '0;
         r_b           <= '0;
         r_is_branch   <= 1'b0;
         r_rsp_result  <= '0;
         r_rsp_taken   <= 1'b0;
         r_rsp_illegal <= 1'b0;
      end else begin
         if (w_accept) begin
            if (w_dec.illegal) begin
               r_rsp_result  <= '0;
               r_rsp_taken   <= 1'b0;
               r_rsp_illegal <= 1'b1;
            end else begin
               r_op        <= w_dec.op;
               r_a         <= w_dec.a;
               r_b         <= w_dec.b;
               r_is_branch <= w_dec.is_branch;
            end
         end
         if (r_state == ST_EXEC) begin
            r_rsp_result  <= ALU_Result_i;
            r_rsp_taken   <= r_is_branch & Zero_i;
            r_rsp_illegal <= 1'b0;
         end
      end
   end

   // Gating with reset keeps ready low while reset is held, even though the state reads IDLE
   assign Req_Ready_o        = (r_state == ST_IDLE) & reset;
   assign Rsp_Valid_o        = (r_state == ST_RESP);
   assign ALU_Operation_o    = r_op;
   assign A_o                = r_a;
   assign B_o                = r_b;
   assign Rsp_Result_o       = r_rsp_result;
   assign Rsp_Branch_Taken_o = r_rsp_taken;
   assign Rsp_Illegal_o      = r_rsp_illegal;
   assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, reset-in-flight sequence, and random requests
// checked against a behavioural decode/ALU model.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic        clk;
   logic        reset;
   logic        Req_Valid_i;
   logic        Req_Ready_o;
   logic [6:0]  Opcode_i;
   logic [2:0]  Funct3_i;
   logic [0:0]  Funct7b5_i;
   logic [31:0] Rs1_i, Rs2_i, Imm_i, PC_i;
   logic [3:0]  ALU_Operation_o;
   logic [31:0] A_o, B_o;
   logic [31:0] ALU_Result_i;
   logic        Zero_i;
   logic        Rsp_Valid_o;
   logic        Rsp_Ready_i;
   logic [31:0] Rsp_Result_o;
   logic        Rsp_Branch_Taken_o;
   logic        Rsp_Illegal_o;
   logic [1:0]  dbg_state;

   int n_checks;
   int n_fail;

`ifdef ALU_SEQ_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] rs1, rs2, imm, pc;
      logic        ill;
      logic [3:0]  op;
      logic [31:0] a, b, res;
      logic        taken;
      int          hold;
   } vec_t;

   vec_t vecs[18];

   alu_sequencer dut (
      .clk                (clk),
      .reset              (reset),
      .Req_Valid_i        (Req_Valid_i),
      .Req_Ready_o        (Req_Ready_o),
      .Opcode_i           (Opcode_i),
      .Funct3_i           (Funct3_i),
      .Funct7b5_i         (Funct7b5_i),
      .Rs1_i              (Rs1_i),
      .Rs2_i              (Rs2_i),
      .Imm_i              (Imm_i),
      .PC_i               (PC_i),
      .ALU_Operation_o    (ALU_Operation_o),
      .A_o                (A_o),
      .B_o                (B_o),
      .ALU_Result_i       (ALU_Result_i),
      .Zero_i             (Zero_i),
      .Rsp_Valid_o        (Rsp_Valid_o),
      .Rsp_Ready_i        (Rsp_Ready_i),
      .Rsp_Result_o       (Rsp_Result_o),
      .Rsp_Branch_Taken_o (Rsp_Branch_Taken_o),
      .Rsp_Illegal_o      (Rsp_Illegal_o),
      .o_dbg_state        (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // ---------------- external ALU model ----------------
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_ADD:   return a + b;
         ALU_SUB:   return a - b;
         ALU_OR:    return a | b;
         ALU_AND:   return a & b;
         ALU_XOR:   return a ^ b;
         ALU_LUI:   return b << 12;
         ALU_SLL:   return a << b[4:0];
         ALU_SRL:   return a >> b[4:0];
         ALU_BEQ:   return a - b;
         ALU_BNE:   return (a == b) ? 32'd1 : 32'd0;
         ALU_AUIPC: return a + (b << 12);
         default:   return 32'd0;
      endcase
   endfunction

   always_comb ALU_Result_i = alu_fn(ALU_Operation_o, A_o, B_o);
   assign Zero_i = (ALU_Result_i == 32'd0);

   // ---------------- reference decode ----------------
   function automatic void ref_decode(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                      input logic [31:0] rs1, input logic [31:0] rs2,
                                      input logic [31:0] imm, input logic [31:0] pc,
                                      output logic ill, output logic [3:0] op,
                                      output logic [31:0] a, output logic [31:0] b);
      logic [31:0] f3_ops;
      logic [7:0]  f3_legal;
      f3_ops   = {ALU_AND, ALU_OR, ALU_SRL, ALU_XOR, 4'd0, 4'd0, ALU_SLL, ALU_ADD};
      f3_legal = SHIFT_EN ? 8'b1111_0011 : 8'b1101_0001;
      ill = 1'b1; op = 4'd0; a = 32'd0; b = 32'd0;
      if (opc == OPC_R || opc == OPC_I) begin
         op  = f3_ops[{f3, 2'b00} +: 4];
         ill = !f3_legal[f3];
         if (f3 == 3'd5 && f7) ill = 1'b1;
         if (opc == OPC_R && f7 && f3 != 3'd0 && f3 != 3'd5) ill = 1'b1;
         if (opc == OPC_R && f7 && f3 == 3'd0) op = ALU_SUB;
         a = rs1;
         b = (opc == OPC_R) ? rs2 : imm;
      end else if (opc == OPC_LUI) begin
         ill = 1'b0; op = ALU_LUI; b = imm;
      end else if (opc == OPC_AUIPC) begin
         ill = 1'b0; op = ALU_AUIPC; a = pc; b = imm;
      end else if (opc == OPC_BRANCH && f3 <= 3'd1) begin
         ill = 1'b0; op = (f3 == 3'd1) ? ALU_BNE : ALU_BEQ; a = rs1; b = rs2;
      end
   endfunction

   function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic ill, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic taken, input int hold);
      vec_t v;
      v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
      v.ill = ill; v.op = op; v.a = a; v.b = b; v.res = res; v.taken = taken; v.hold = hold;
      return v;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // Entered one time unit after a rising edge with the DUT idle; leaves it idle the same way.
   task automatic run_req(input vec_t v, input string tag);
      check({tag, ":req_ready_idle"}, 32'(Req_Ready_o), 32'd1);
      Opcode_i = v.opc; Funct3_i = v.f3; Funct7b5_i = v.f7;
      Rs1_i = v.rs1; Rs2_i = v.rs2; Imm_i = v.imm; PC_i = v.pc;
      Req_Valid_i = 1'b1;
      @(posedge clk); #1;
      Req_Valid_i = 1'b0;
      Opcode_i = 7'($urandom); Rs1_i = $urandom; Rs2_i = $urandom; Imm_i = $urandom; PC_i = $urandom;
      if (!v.ill) begin
         check({tag, ":exec_op"}, 32'(ALU_Operation_o), 32'(v.op));
         check({tag, ":exec_a"}, A_o, v.a);
         check({tag, ":exec_b"}, B_o, v.b);
         check({tag, ":exec_no_valid"}, 32'(Rsp_Valid_o), 32'd0);
         check({tag, ":exec_not_ready"}, 32'(Req_Ready_o), 32'd0);
         @(posedge clk); #1;
      end
      check({tag, ":rsp_valid"}, 32'(Rsp_Valid_o), 32'd1);
      check({tag, ":rsp_illegal"}, 32'(Rsp_Illegal_o), 32'(v.ill));
      check({tag, ":rsp_result"}, Rsp_Result_o, v.res);
      check({tag, ":rsp_taken"}, 32'(Rsp_Branch_Taken_o), 32'(v.taken));
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk); #1;
         check({tag, ":hold_valid"}, 32'(Rsp_Valid_o), 32'd1);
         check({tag, ":hold_result"}, Rsp_Result_o, v.res);
         check({tag, ":hold_taken"}, 32'(Rsp_Branch_Taken_o), 32'(v.taken));
         check({tag, ":hold_not_ready"}, 32'(Req_Ready_o), 32'd0);
         if (!v.ill) check({tag, ":hold_a"}, A_o, v.a);
      end
      Rsp_Ready_i = 1'b1;
      @(posedge clk); #1;
      Rsp_Ready_i = 1'b0;
      check({tag, ":rsp_done"}, 32'(Rsp_Valid_o), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ":req_ready"}, 32'(Req_Ready_o), 32'd0);
      check({tag, ":rsp_valid"}, 32'(Rsp_Valid_o), 32'd0);
      check({tag, ":alu_op"}, 32'(ALU_Operation_o), 32'd0);
      check({tag, ":a"}, A_o, 32'd0);
      check({tag, ":b"}, B_o, 32'd0);
      check({tag, ":result"}, Rsp_Result_o, 32'd0);
      check({tag, ":taken"}, 32'(Rsp_Branch_Taken_o), 32'd0);
      check({tag, ":illegal"}, 32'(Rsp_Illegal_o), 32'd0);
   endtask

   // ---------------- test ----------------
   initial begin
      n_checks = 0; n_fail = 0;
      reset = 1'b0; Req_Valid_i = 1'b0; Rsp_Ready_i = 1'b0;
      Opcode_i = '0; Funct3_i = '0; Funct7b5_i = '0;
      Rs1_i = '0; Rs2_i = '0; Imm_i = '0; PC_i = '0;

      vecs[0]  = mk(OPC_R, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0, 1'b0, ALU_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 0);
      vecs[1]  = mk(OPC_R, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1);
      vecs[2]  = mk(OPC_R, 3'b110, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 32'd0, 1'b0, ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 0);
      vecs[3]  = mk(OPC_R, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'd0, 1'b0, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 0);
      vecs[4]  = mk(OPC_I, 3'b100, 1'b0, 32'hAAAA_AAAA, 32'h1234, 32'hFFFF_FFFF, 32'd0, 1'b0, ALU_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 0);
      vecs[5]  = mk(OPC_I, 3'b000, 1'b1, 32'd5, 32'd77, 32'hFFFF_FFFF, 32'd0, 1'b0, ALU_ADD, 32'd5, 32'hFFFF_FFFF, 32'd4, 1'b0, 2);
      vecs[6]  = mk(OPC_LUI, 3'b000, 1'b0, 32'd99, 32'd0, 32'h0001_2345, 32'd0, 1'b0, ALU_LUI, 32'd0, 32'h0001_2345, 32'h1234_5000, 1'b0, 0);
      vecs[7]  = mk(OPC_AUIPC, 3'b000, 1'b0, 32'd0, 32'd0, 32'd1, 32'h100, 1'b0, ALU_AUIPC, 32'h100, 32'd1, 32'h1100, 1'b0, 5);
      vecs[8]  = mk(OPC_BRANCH, 3'b000, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0, ALU_BEQ, 32'd5, 32'd5, 32'd0, 1'b1, 0);
      vecs[9]  = mk(OPC_BRANCH, 3'b001, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0, ALU_BNE, 32'd5, 32'd6, 32'd0, 1'b1, 0);
      vecs[10] = mk(OPC_BRANCH, 3'b001, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0, ALU_BNE, 32'd5, 32'd5, 32'd1, 1'b0, 0);
      vecs[11] = mk(OPC_BRANCH, 3'b000, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0, ALU_BEQ, 32'd5, 32'd6, 32'hFFFF_FFFF, 1'b0, 1);
      vecs[12] = mk(7'b1111111, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3);
`ifdef ALU_SEQ_SHIFT_EN
      vecs[13] = mk(OPC_R, 3'b001, 1'b0, 32'd1, 32'd3, 32'd0, 32'd0, 1'b0, ALU_SLL, 32'd1, 32'd3, 32'd8, 1'b0, 0);
      vecs[17] = mk(OPC_I, 3'b101, 1'b0, 32'h80, 32'd0, 32'd4, 32'd0, 1'b0, ALU_SRL, 32'h80, 32'd4, 32'h8, 1'b0, 0);
`else
      vecs[13] = mk(OPC_R, 3'b001, 1'b0, 32'd1, 32'd3, 32'd0, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);
      vecs[17] = mk(OPC_I, 3'b101, 1'b0, 32'h80, 32'd0, 32'd4, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);
`endif
      vecs[14] = mk(OPC_R, 3'b101, 1'b1, 32'h80, 32'd4, 32'd0, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);
      vecs[15] = mk(OPC_R, 3'b100, 1'b1, 32'd3, 32'd5, 32'd0, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);
      vecs[16] = mk(OPC_BRANCH, 3'b010, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1);

      #1;
      check_all_zero("in_reset");
      #20;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("post_reset:req_ready", 32'(Req_Ready_o), 32'd1);
      check("post_reset:rsp_valid", 32'(Rsp_Valid_o), 32'd0);

      for (int i = 0; i < 18; i++) run_req(vecs[i], $sformatf("vec%0d", i));

      // reset pulled while a request sits in EXEC: everything clears at once, no response later
      Opcode_i = OPC_R; Funct3_i = 3'b000; Funct7b5_i = 1'b0;
      Rs1_i = 32'd20; Rs2_i = 32'd22; Req_Valid_i = 1'b1;
      @(posedge clk); #1;
      Req_Valid_i = 1'b0;
      check("rst_exec:op", 32'(ALU_Operation_o), 32'(ALU_ADD));
      check("rst_exec:a", A_o, 32'd20);
      #2 reset = 1'b0;
      #1;
      check_all_zero("rst_exec_async");
      @(posedge clk); #1;
      check("rst_exec:held_valid", 32'(Rsp_Valid_o), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("rst_exec:no_rsp", 32'(Rsp_Valid_o), 32'd0);
         check("rst_exec:ready", 32'(Req_Ready_o), 32'd1);
      end

      for (int k = 0; k < 40; k++) begin
         vec_t v;
         case ($urandom_range(0, 5))
            0:       v.opc = OPC_R;
            1:       v.opc = OPC_I;
            2:       v.opc = OPC_LUI;
            3:       v.opc = OPC_AUIPC;
            4:       v.opc = OPC_BRANCH;
            default: v.opc = 7'($urandom);
         endcase
         v.f3  = 3'($urandom);
         v.f7  = 1'($urandom);
         v.rs1 = $urandom;
         v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
         v.imm = $urandom;
         v.pc  = $urandom;
         ref_decode(v.opc, v.f3, v.f7, v.rs1, v.rs2, v.imm, v.pc, v.ill, v.op, v.a, v.b);
         v.res   = v.ill ? 32'd0 : alu_fn(v.op, v.a, v.b);
         v.taken = !v.ill && ((v.op == ALU_BEQ && v.a == v.b) || (v.op == ALU_BNE && v.a != v.b));
         v.hold  = $urandom_range(0, 3);
         run_req(v, $sformatf("rand%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
- REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
- REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
- REQ-003 SHALL have port Req_Valid_i  input  1  request present.
- REQ-004 SHALL have port Req_Ready_o  output  1  request accepted when Req_Valid_i & Req_Ready_o.
- REQ-005 SHALL have ports Opcode_i [6:0], Funct3_i [2:0], Funct7b5_i [0:0]  input  instruction fields.
- REQ-006 SHALL have ports Rs1_i, Rs2_i, Imm_i, PC_i  input  32 each  operand sources.
- REQ-007 SHALL have port ALU_Operation_o  output  4  drives the ALU operation code.
- REQ-008 SHALL have ports A_o, B_o  output  32 each  ALU operands.
- REQ-009 SHALL have ports ALU_Result_i  input  32, Zero_i  input  1  combinational ALU return.
- REQ-010 SHALL have ports Rsp_Valid_o  output  1, Rsp_Ready_i  input  1  response handshake.
- REQ-011 SHALL have ports Rsp_Result_o  output  32, Rsp_Branch_Taken_o  output  1, Rsp_Illegal_o  output  1.

Function
- REQ-012 SHALL use op codes ADD=0, SUB=1, OR=2, AND=3, XOR=4, LUI=5, SLL=6, SRL=7, BEQ=8, BNE=9, AUIPC=15.
- REQ-013 SHALL decode opcode 0110011 (R): funct3 000->ADD, or SUB if Funct7b5_i; 110 OR; 111 AND; 100 XOR; 001 SLL; 101 SRL; A=Rs1, B=Rs2.
- REQ-014 SHALL decode opcode 0010011 (I) as R except funct3 000 always ADD; B=Imm_i.
- REQ-015 SHALL decode 0110111 LUI (A=0, B=Imm_i, unshifted upper field), 0010111 AUIPC (A=PC_i, B=Imm_i).
- REQ-016 SHALL decode 1100011 funct3 000->BEQ, 001->BNE; A=Rs1, B=Rs2.
- REQ-017 SHALL flag illegal: any other opcode/funct3, funct3 101 with Funct7b5_i=1 (SRA/SRAI unsupported), funct7b5=1 on R-type funct3 other than 000/101.
- REQ-018 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; Req_Ready_o=1 only in IDLE.
- REQ-019 SHALL on accept register op, A_o, B_o and enter EXEC; illegal request goes directly to RESP with Rsp_Illegal_o=1, Rsp_Result_o=0, taken=0.
- REQ-020 SHALL in EXEC hold ALU_Operation_o/A_o/B_o stable for one full cycle and capture ALU_Result_i and Zero_i at its closing edge, entering RESP.
- REQ-021 SHALL set Rsp_Branch_Taken_o = Zero_i for BEQ and BNE, 0 otherwise; Rsp_Result_o = captured ALU_Result_i.
- REQ-022 SHALL assert Rsp_Valid_o in RESP and hold all Rsp_* stable until Rsp_Ready_i; return to IDLE on that edge.
- REQ-023 SHALL yield latency: accept at edge N, Rsp_Valid_o high after edge N+2 (legal) or N+1 (illegal); max throughput one request per 3 cycles.
- REQ-024 SHALL hold ALU-side outputs at last issued values outside EXEC.

Reset
- REQ-025 SHALL, on reset low, immediately force state IDLE and all outputs 0 (Req_Ready_o=0 while reset asserted, 1 in first cycle after release).
- REQ-026 SHALL drop any in-flight request or pending response on reset with no response emitted.

Configuration
- REQ-027 SHALL with ALU_SEQ_SHIFT_EN defined decode SLL/SRL per REQ-013/014; without it funct3 001/101 on R/I opcodes SHALL be illegal.

Structure
- REQ-028 SHALL place op-code localparams, RISC-V opcode constants and FSM state encoding in shared package alu_seq_pkg.
- REQ-029 SHALL implement decode (REQ-013..017, REQ-027) in combinational sub-module alu_seq_decoder.

Verification
- REQ-030 R-type funct3 000 Funct7b5=1, Rs1=10, Rs2=3 -> ALU_Operation_o=1 in EXEC; with ALU model Rsp_Result_o=7, valid two edges after accept.
- REQ-031 BEQ Rs1=Rs2=5 -> op 8, taken=1; BNE Rs1=5, Rs2=6 -> op 9, ALU returns 0, taken=1; BNE equal -> taken=0.
- REQ-032 AUIPC PC=0x100, Imm=0x1 -> op 15, A_o=0x100, B_o=1, Rsp_Result_o=0x1100.
- REQ-033 Opcode 1111111 -> Rsp_Illegal_o=1, result 0, valid one edge after accept, no EXEC cycle.
- REQ-034 Rsp_Ready_i low 5 cycles -> Rsp_* stable, Req_Ready_o=0 throughout; new request accepted the cycle after RESP handshake.
- REQ-035 reset pulled low during EXEC -> outputs 0 asynchronously, no response; SLL request without ALU_SEQ_SHIFT_EN -> illegal.
